seg_scan_driver: RTL

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the adder/hex-decode stage. It captures four 4-bit digit values (e.g. A, B, sum, flags) and scans them onto a common-anode display, one digit per refresh slot, with its own hex decode. It also provides leading-zero blanking and an overflow blink. All updates are frame-synchronous, so digits never tear mid-scan.

---
 rtl/seg_scan_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scanner with frame-synchronous
// digit capture, hex decode, leading-zero blanking and overflow blink.
//
// state | meaning
// SCAN0 | digit 0 (rightmost) slot active
// SCAN1 | digit 1 slot active
// SCAN2 | digit 2 slot active
// SCAN3 | digit 3 slot active; its slot tick is the frame boundary
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lzs,
  input  logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} state_t;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic          pend;
  logic [15:0]   pend_digits;
  logic [3:0]    pend_dp;
  logic          pend_lzs;
  logic          pend_ovf;

  logic [15:0]   sh_digits;
  logic [3:0]    sh_dp;
  logic          sh_lzs;
  logic          sh_ovf;

  logic          slot_tick;
  logic          frame_end;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_tick = (pre_cnt == PW'(REFRESH_DIV - 1));
  assign frame_end = slot_tick && (state == SCAN3);
  assign idx       = state;
  assign nib       = sh_digits[{idx, 2'b00} +: 4];
  // Shifting right fills with zeros, so this tests digit idx and all above it.
  assign lz_blank  = sh_lzs && (idx != 2'd0) && ((sh_digits >> {idx, 2'b00}) == 16'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SCAN0;
      pre_cnt     <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      pend        <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_lzs    <= 1'b0;
      pend_ovf    <= 1'b0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_lzs      <= 1'b0;
      sh_ovf      <= 1'b0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
    end else begin
      pre_cnt <= slot_tick ? '0 : pre_cnt + PW'(1);

      if (slot_tick) begin
        case (state)
          SCAN0: state <= SCAN1;
          SCAN1: state <= SCAN2;
          SCAN2: state <= SCAN3;
          SCAN3: state <= SCAN0;
          default: state <= SCAN0;
        endcase
      end

      if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      // A load landing on the boundary goes straight to shadow.
      if (frame_end && load) begin
        sh_digits <= digits;
        sh_dp     <= dp_in;
        sh_lzs    <= lzs;
        sh_ovf    <= overflow;
        pend      <= 1'b0;
      end else if (frame_end && pend) begin
        sh_digits <= pend_digits;
        sh_dp     <= pend_dp;
        sh_lzs    <= pend_lzs;
        sh_ovf    <= pend_ovf;
        pend      <= 1'b0;
      end else if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp_in;
        pend_lzs    <= lzs;
        pend_ovf    <= overflow;
        pend        <= 1'b1;
      end

      if (lz_blank) begin
        an  <= 4'hF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= (sh_ovf && phase) ? 4'hF : ~(4'b0001 << idx);
        seg <= hex7(nib);
        dp  <= ~sh_dp[idx];
      end
    end
  end

endmodule
